// File: rtl/serial_pkg.sv
// Shared FSM state type, parity mode constants and parity helper for the
// parametrised serial frame receiver.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // xor_bit is the XOR of all data bits and the received parity bit
   function automatic logic parity_error(input logic xor_bit, input int mode);
      logic err;
      case (mode)
         PAR_EVEN: err = xor_bit;
         PAR_ODD:  err = ~xor_bit;
         default:  err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period phase counter: after a restart at t0 it strobes at phase H of
// every bit period, where H = floor((C-1)/2) is the mid-bit sample point.
module serial_bit_timer
   import serial_pkg::*;
#(
   parameter int C = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic sample
);

   localparam int              PW      = $clog2(C) + 1;
   localparam logic [PW-1:0]   H_P     = PW'((C - 1) / 2);
   localparam logic [PW-1:0]   LAST_P  = PW'(C - 1);
   // The restart cycle itself is phase 0, so the following cycle is phase 1
   localparam logic [PW-1:0]   FIRST_P = PW'((C == 1) ? 0 : 1);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   always_comb begin
      if (restart) begin
         phase_d = FIRST_P;
      end else if (phase_q == LAST_P) begin
         phase_d = {PW{1'b0}};
      end else begin
         phase_d = phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= {PW{1'b0}};
      end else begin
         phase_q <= phase_d;
      end
   end

   assign sample = (phase_q == H_P);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver with configurable data width, parity, stop bits and
// oversampled mid-bit sampling; emits data, a done strobe and error flags.
module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 din,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 parity_err,
   output logic                 frame_err
);

   localparam int            CW       = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
   // With H = 0 the start bit is sampled at t0 itself, so the first strobe
   // seen in START already belongs to data bit 0.
   localparam bit            H_ZERO   = (((CLKS_PER_BIT - 1) / 2) == 0);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  par_q, par_d;
   logic                  done_q, done_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;
   logic [DATA_BITS-1:0]  shift_in;
   logic                  restart;
   logic                  sample;

   serial_bit_timer #(.C(CLKS_PER_BIT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .sample  (sample)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!din) state_d = ST_START;
            else      state_d = ST_IDLE;
         end
         ST_START: begin
            if (!sample)     state_d = ST_START;
            else if (H_ZERO) state_d = ST_DATA;
            else if (din)    state_d = ST_IDLE;
            else             state_d = ST_DATA;
         end
         ST_DATA: begin
            if (sample && (cnt_q == LAST_BIT))
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP1;
            else
               state_d = ST_DATA;
         end
         ST_PARITY: begin
            if (sample) state_d = ST_STOP1;
            else        state_d = ST_PARITY;
         end
         ST_STOP1: begin
            if (!sample)             state_d = ST_STOP1;
            else if (!din)           state_d = ST_ERR;
            else if (STOP_BITS == 2) state_d = ST_STOP2;
            else                     state_d = ST_DONE;
         end
         ST_STOP2: begin
            if (!sample)   state_d = ST_STOP2;
            else if (!din) state_d = ST_ERR;
            else           state_d = ST_DONE;
         end
         ST_DONE: begin
            if (din) state_d = ST_IDLE;
            else     state_d = ST_START;
         end
         ST_ERR: begin
            if (din) state_d = ST_IDLE;
            else     state_d = ST_ERR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      restart  = 1'b0;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      shift_in = {din, shift_q[DATA_BITS-1:1]};
      case (state_q)
         ST_IDLE, ST_DONE: begin
            restart = ~din;
            cnt_d   = {CW{1'b0}};
         end
         ST_START: begin
            if (sample && H_ZERO) begin
               shift_d = shift_in;
               cnt_d   = CW'(1);
            end else begin
               shift_d = shift_q;
               cnt_d   = cnt_q;
            end
         end
         ST_DATA: begin
            if (sample) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + CW'(1);
            end else begin
               shift_d = shift_q;
               cnt_d   = cnt_q;
            end
         end
         ST_PARITY: begin
            if (sample) par_d = din;
            else        par_d = par_q;
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
      done_d = (state_d == ST_DONE);
      ferr_d = (state_d == ST_ERR) && (state_q != ST_ERR);
      perr_d = done_d && parity_error((^shift_q) ^ par_q, PARITY);
      if (done_d) data_d = shift_q;
      else        data_d = data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= {CW{1'b0}};
         shift_q <= {DATA_BITS{1'b0}};
         data_q  <= {DATA_BITS{1'b0}};
         par_q   <= 1'b0;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         par_q   <= par_d;
         done_q  <= done_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data       = data_q;
   assign done       = done_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule
